// File: rtl/decode_stage_pkg.sv
// Shared decode constants and types for decode_stage.
// ALU codes, RV32I opcodes, operand-select codes and the decoded bundle.
package decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_SEQ  = 4'd10;
    localparam logic [3:0] ALU_SNE  = 4'd11;
    localparam logic [3:0] ALU_SGE  = 4'd12;
    localparam logic [3:0] ALU_SGEU = 4'd13;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic       SRC2_RS2  = 1'b0;
    localparam logic       SRC2_IMM  = 1'b1;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [1:0]  src1_sel;
        logic        src2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_funct3;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } dec_t;

    // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle.
// master: the decode stage; slave: the fetch/execute environment.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_src1_sel;
    logic        out_src2_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic [2:0]  out_mem_funct3;
    logic        out_branch;
    logic        out_jal;
    logic        out_jalr;
    logic        out_illegal;

    modport master (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_op, out_src1_sel, out_src2_sel,
               out_imm, out_rs1, out_rs2, out_rd, out_reg_we, out_mem_rd, out_mem_wr,
               out_mem_funct3, out_branch, out_jal, out_jalr, out_illegal
    );

    modport slave (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_op, out_src1_sel, out_src2_sel,
               out_imm, out_rs1, out_rs2, out_rd, out_reg_we, out_mem_rd, out_mem_wr,
               out_mem_funct3, out_branch, out_jal, out_jalr, out_illegal
    );

endinterface

// File: rtl/decode_stage_comb.sv
// decode_comb: purely combinational RV32I instruction -> dec_t decode.
// Macro DECODE_ILLEGAL_TRAP_EN: flag illegal encodings instead of turning them into a NOP.
module decode_comb
    import decode_stage_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        ill;
    dec_t        raw;

    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    // Field decode by opcode, plus legality of funct3/funct7
    always_comb begin
        raw          = '0;
        ill          = 1'b0;
        raw.alu_op   = ALU_ADD;
        raw.src1_sel = SRC1_RS1;
        raw.src2_sel = SRC2_IMM;
        raw.rs1      = inst[19:15];
        raw.rs2      = inst[24:20];
        raw.rd       = inst[11:7];
        case (opc)
            OPC_OP: begin
                raw.alu_op   = alu_fn(f3, f7[5]);
                raw.src2_sel = SRC2_RS2;
                raw.reg_we   = 1'b1;
                ill = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                raw.alu_op = alu_fn(f3, (f3 == 3'b101) && f7[5]);
                raw.imm    = imm_i;
                raw.reg_we = 1'b1;
                if (f3 == 3'b001) begin
                    raw.imm = imm_sh;
                    ill     = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    raw.imm = imm_sh;
                    ill     = (f7 != 7'h00) && (f7 != 7'h20);
                end
            end
            OPC_LOAD: begin
                raw.imm        = imm_i;
                raw.mem_rd     = 1'b1;
                raw.reg_we     = 1'b1;
                raw.mem_funct3 = f3;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                raw.imm        = imm_s;
                raw.mem_wr     = 1'b1;
                raw.mem_funct3 = f3;
                ill = f3[2] || (f3 == 3'b011);
            end
            OPC_BRANCH: begin
                raw.src2_sel = SRC2_RS2;
                raw.imm      = imm_b;
                raw.branch   = 1'b1;
                case (f3)
                    3'b000:  raw.alu_op = ALU_SEQ;
                    3'b001:  raw.alu_op = ALU_SNE;
                    3'b100:  raw.alu_op = ALU_SLT;
                    3'b101:  raw.alu_op = ALU_SGE;
                    3'b110:  raw.alu_op = ALU_SLTU;
                    3'b111:  raw.alu_op = ALU_SGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                raw.src1_sel = SRC1_ZERO;
                raw.imm      = imm_u;
                raw.reg_we   = 1'b1;
            end
            OPC_AUIPC: begin
                raw.src1_sel = SRC1_PC;
                raw.imm      = imm_u;
                raw.reg_we   = 1'b1;
            end
            OPC_JAL: begin
                raw.src1_sel = SRC1_PC;
                raw.imm      = imm_j;
                raw.jal      = 1'b1;
                raw.reg_we   = 1'b1;
            end
            OPC_JALR: begin
                raw.imm    = imm_i;
                raw.jalr   = 1'b1;
                raw.reg_we = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) ill = 1'b1;
        if (raw.rd == 5'd0) raw.reg_we = 1'b0;
    end

    // Illegal handling: trap flag with side effects suppressed, or plain NOP
    always_comb begin
        dec = raw;
        if (ill) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
            dec.alu_op  = ALU_ADD;
            dec.reg_we  = 1'b0;
            dec.mem_rd  = 1'b0;
            dec.mem_wr  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
`else
            dec          = '0;
            dec.alu_op   = ALU_ADD;
            dec.src1_sel = SRC1_RS1;
            dec.src2_sel = SRC2_IMM;
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode output with a one-entry skid behind it.
// in_ready comes straight from a flop, so fetch never sees a combinational path from execute.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.master bus
);

    dec_t            dec_new;
    logic            accept, consume;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    dec_t            out_dec_q, out_dec_d;
    dec_t            skid_dec_q, skid_dec_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    decode_comb u_dec (
        .inst (bus.in_inst),
        .dec  (dec_new)
    );

    assign accept  = bus.in_valid && !skid_valid_q;
    assign consume = out_valid_q && bus.out_ready;

    // Output/skid next state: refill output from skid first to keep FIFO order
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_dec_d    = out_dec_q;
        skid_dec_d   = skid_dec_q;
        out_pc_d     = out_pc_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_dec_d    = skid_dec_q;
                out_pc_d     = skid_pc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_dec_d   = dec_new;
                out_pc_d    = bus.in_pc;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_dec_d   = dec_new;
            skid_pc_d    = bus.in_pc;
            skid_valid_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_dec_q    <= '0;
            skid_dec_q   <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_dec_q    <= out_dec_d;
            skid_dec_q   <= skid_dec_d;
            out_pc_q     <= out_pc_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign bus.in_ready       = !skid_valid_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_alu_op     = out_dec_q.alu_op;
    assign bus.out_src1_sel   = out_dec_q.src1_sel;
    assign bus.out_src2_sel   = out_dec_q.src2_sel;
    assign bus.out_imm        = out_dec_q.imm;
    assign bus.out_rs1        = out_dec_q.rs1;
    assign bus.out_rs2        = out_dec_q.rs2;
    assign bus.out_rd         = out_dec_q.rd;
    assign bus.out_reg_we     = out_dec_q.reg_we;
    assign bus.out_mem_rd     = out_dec_q.mem_rd;
    assign bus.out_mem_wr     = out_dec_q.mem_wr;
    assign bus.out_mem_funct3 = out_dec_q.mem_funct3;
    assign bus.out_branch     = out_dec_q.branch;
    assign bus.out_jal        = out_dec_q.jal;
    assign bus.out_jalr       = out_dec_q.jalr;
    assign bus.out_illegal    = out_dec_q.illegal;

endmodule
